// File: rtl/coin_seq_pkg.sv
// Shared types and default timing for the coin/start input sequencer.
package coin_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COIN,
    GAP,
    START,
    WAIT_REL
  } state_t;

  typedef enum logic [1:0] {
    P1,
    P2,
    COIN_ONLY
  } sel_t;

  localparam int DEF_COIN_FRAMES  = 4;
  localparam int DEF_GAP_FRAMES   = 8;
  localparam int DEF_START_FRAMES = 4;
  localparam int DEF_P2_COINS     = 2;
  localparam int DEF_CNT_W        = 5;

endpackage

// File: rtl/coin_start_seq_vblank_tick.sv
// One-cycle frame tick, registered on the cycle after a vblank rising edge is captured.
module vblank_tick (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vblank,
  output logic tick
);

  logic vblank_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
      tick     <= 1'b0;
    end else begin
      vblank_q <= vblank;
      tick     <= vblank & ~vblank_q;
    end
  end

endmodule

// File: rtl/coin_start_seq.sv
// Turns Start 1P/2P presses into frame-timed coin bursts followed by a start pulse.
// Optional COIN_SEQ_MANUAL_COIN_EN adds req_coin for a coin-only sequence.
module coin_start_seq
  import coin_seq_pkg::*;
#(
  parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
  parameter int GAP_FRAMES   = DEF_GAP_FRAMES,
  parameter int START_FRAMES = DEF_START_FRAMES,
  parameter int P2_COINS     = DEF_P2_COINS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic vblank,
  input  logic req_start1,
  input  logic req_start2,
`ifdef COIN_SEQ_MANUAL_COIN_EN
  input  logic req_coin,
`endif
  output logic coin_out,
  output logic start1_out,
  output logic start2_out,
  output logic busy
);

  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_FRAMES - 1);
  localparam logic [CNT_W-1:0] P2_LOAD    = CNT_W'(P2_COINS);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam bit               HAS_GAP    = (GAP_FRAMES != 0);

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] coins_q, coins_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] coins_dec;
  state_t           after_coin;
  logic             tick;
  logic             manual_coin;
  logic             any_held;

`ifdef COIN_SEQ_MANUAL_COIN_EN
  assign manual_coin = req_coin;
`else
  assign manual_coin = 1'b0;
`endif

  assign any_held = req_start1 | req_start2 | manual_coin;

  vblank_tick u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .vblank  (vblank),
    .tick    (tick)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // Where a sequence goes once the current coin (and its gap, if any) is done.
  function automatic state_t next_step(input logic [CNT_W-1:0] coins, input sel_t sel);
    if (coins != '0)       return COIN;
    else if (sel == COIN_ONLY) return WAIT_REL;
    else                   return START;
  endfunction

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    coins_d    = coins_q;
    cnt_d      = cnt_q;
    coins_dec  = (coins_q != '0) ? coins_q - ONE : '0;
    after_coin = next_step(coins_dec, sel_q);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_start2) begin
          sel_d   = P2;
          coins_d = P2_LOAD;
          state_d = COIN;
        end else if (req_start1) begin
          sel_d   = P1;
          coins_d = ONE;
          state_d = COIN;
        end else if (manual_coin) begin
          sel_d   = COIN_ONLY;
          coins_d = ONE;
          state_d = COIN;
        end
      end
      COIN: if (tick) begin
        if (cnt_q == COIN_LAST) begin
          coins_d = coins_dec;
          cnt_d   = '0;
          state_d = HAS_GAP ? GAP : after_coin;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      GAP: if (tick) begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = next_step(coins_q, sel_q);
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      START: if (tick) begin
        if (cnt_q == START_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_REL;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      WAIT_REL: if (!any_held) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decode the current state, so they trail each state change by one edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= P1;
      coins_q    <= '0;
      cnt_q      <= '0;
      coin_out   <= 1'b0;
      start1_out <= 1'b0;
      start2_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      coins_q    <= coins_d;
      cnt_q      <= cnt_d;
      coin_out   <= (state_q == COIN);
      start1_out <= (state_q == START) && (sel_q == P1);
      start2_out <= (state_q == START) && (sel_q == P2);
    end
  end

  assign busy = (state_q != IDLE);

endmodule
